// File: rtl/uart_auto_baud_if.sv
// rtl/uart_auto_baud_if.sv - control and status bundle between auto-baud detector and its host
interface uart_auto_baud_if;
    logic        start;
    logic        rx;
    logic        manual_load;
    logic [31:0] manual_division;
    logic [31:0] baud_division;
    logic        gen_rst;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, rx, manual_load, manual_division,
        input  baud_division, gen_rst, busy, done, error
    );

    modport slave (
        input  start, rx, manual_load, manual_division,
        output baud_division, gen_rst, busy, done, error
    );
endinterface

// File: rtl/uart_auto_baud.sv
// rtl/uart_auto_baud.sv - measures a 0x55 frame on rx and derives the baud-rate divisor
module uart_auto_baud #(
    parameter int unsigned DEFAULT_DIV = 867,
    parameter int unsigned DIV_MIN     = 15,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    uart_auto_baud_if.slave  bus_io
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] baud_q, baud_d;
    logic        gen_rst_q, gen_rst_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        rx_prev_q;
    logic [31:0] meas_cnt_q, meas_cnt_d;
    logic [1:0]  edge_cnt_q, edge_cnt_d;
    logic [31:0] to_cnt_q, to_cnt_d;

    logic        fall;
    logic        timed_out;
    logic [32:0] div_w;
    logic        div_ok;

    assign fall      = rx_prev_q & ~bus_io.rx;
    assign timed_out = (to_cnt_q == 32'(TIMEOUT - 1));

    // T spans 8 bit times; +4 rounds to nearest before the divide by 8.
    assign div_w  = (({1'b0, meas_cnt_q} + 33'd4) >> 3) - 33'd1;
    assign div_ok = ~div_w[32] && (div_w[31:0] >= 32'(DIV_MIN));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            baud_q     <= 32'(DEFAULT_DIV);
            gen_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rx_prev_q  <= 1'b1;
            meas_cnt_q <= '0;
            edge_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            gen_rst_q  <= gen_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
            rx_prev_q  <= bus_io.rx;
            meas_cnt_q <= meas_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        gen_rst_d  = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        meas_cnt_d = meas_cnt_q;
        edge_cnt_d = edge_cnt_q;
        to_cnt_d   = to_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus_io.manual_load) begin
                    baud_d    = bus_io.manual_division;
                    gen_rst_d = 1'b1;
                end else if (bus_io.start) begin
                    state_d    = WAIT_START;
                    meas_cnt_d = '0;
                    edge_cnt_d = '0;
                    to_cnt_d   = '0;
                end
            end

            WAIT_START: begin
                to_cnt_d = to_cnt_q + 32'd1;
                if (fall) begin
                    meas_cnt_d = 32'd1;
                    edge_cnt_d = '0;
                    state_d    = MEASURE;
                end
                if (timed_out) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end

            MEASURE: begin
                to_cnt_d   = to_cnt_q + 32'd1;
                meas_cnt_d = (meas_cnt_q == '1) ? meas_cnt_q : meas_cnt_q + 32'd1;
                if (fall && edge_cnt_q == 2'd3) begin
                    // Fourth fall after the start bit is the bit-7 fall: 8 bit times elapsed.
                    state_d = IDLE;
                    if (div_ok) begin
                        baud_d    = div_w[31:0];
                        gen_rst_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else begin
                    if (fall) begin
                        edge_cnt_d = edge_cnt_q + 2'd1;
                    end
                    if (timed_out) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus_io.baud_division = baud_q;
    assign bus_io.gen_rst       = gen_rst_q;
    assign bus_io.busy          = (state_q != IDLE);
    assign bus_io.done          = done_q;
    assign bus_io.error         = error_q;

endmodule
